// File: rtl/regfile_port_arbiter_if.sv
// Write-port bus of the integer register file arbiter.
//   core_*   : core writeback requester (valid/ready, addr, data)
//   dbg_*    : debug/loader requester   (valid/ready, addr, data)
//   rf_*     : registered write port toward the register file
//   init_busy: clear sequence in progress
// master = requesters + register-file side, slave = the arbiter.
interface regfile_port_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          core_wvalid;
    logic          core_wready;
    logic [AW-1:0] core_waddr;
    logic [DW-1:0] core_wdata;

    logic          dbg_wvalid;
    logic          dbg_wready;
    logic [AW-1:0] dbg_waddr;
    logic [DW-1:0] dbg_wdata;

    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          init_busy;

    modport master (
        output core_wvalid, core_waddr, core_wdata,
        output dbg_wvalid,  dbg_waddr,  dbg_wdata,
        input  core_wready, dbg_wready,
        input  rf_we, rf_waddr, rf_wdata, init_busy
    );

    modport slave (
        input  core_wvalid, core_waddr, core_wdata,
        input  dbg_wvalid,  dbg_waddr,  dbg_wdata,
        output core_wready, dbg_wready,
        output rf_we, rf_waddr, rf_wdata, init_busy
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Owner of the single register-file write port.
// After reset, clears x1..x(NUM_REGS-1) one register per cycle, then
// arbitrates core writeback (priority) and debug/loader (starvation-guarded)
// onto the port. All register-file outputs are registered.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave modport: core_*/dbg_* valid/ready requests in,
//          rf_we/rf_waddr/rf_wdata and init_busy out
module regfile_port_arbiter #(
    parameter int NUM_REGS     = 32,
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_port_arbiter_if.slave bus
);
    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0]  LAST_ADDR  = AW'(NUM_REGS - 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wreq_t;

    state_t         r_state,      w_state_nxt;
    logic [AW-1:0]  r_clr_ptr,    w_clr_ptr_nxt;
    logic [SCW-1:0] r_starve_cnt, w_starve_cnt_nxt;
    logic           r_rf_we,      w_rf_we_nxt;
    wreq_t          r_rf_wr,      w_rf_wr_nxt;
    logic           r_init_busy,  w_init_busy_nxt;

    wreq_t w_core_req;
    wreq_t w_dbg_req;
    logic  w_force_dbg;
    logic  w_core_wready;
    logic  w_dbg_wready;
    logic  w_grant_core;
    logic  w_grant_dbg;

    assign w_core_req = '{addr: bus.core_waddr, data: bus.core_wdata};
    assign w_dbg_req  = '{addr: bus.dbg_waddr,  data: bus.dbg_wdata};

    always_comb begin
        w_state_nxt      = r_state;
        w_clr_ptr_nxt    = r_clr_ptr;
        w_starve_cnt_nxt = r_starve_cnt;
        w_rf_we_nxt      = 1'b0;
        w_rf_wr_nxt      = r_rf_wr;
        w_init_busy_nxt  = r_init_busy;
        w_force_dbg      = 1'b0;
        w_core_wready    = 1'b0;
        w_dbg_wready     = 1'b0;
        w_grant_core     = 1'b0;
        w_grant_dbg      = 1'b0;

        case (r_state)
            S_CLEAR: begin
                w_rf_we_nxt = 1'b1;
                w_rf_wr_nxt = '{addr: r_clr_ptr, data: '0};
                if (r_clr_ptr == LAST_ADDR) begin
                    w_state_nxt     = S_RUN;
                    w_init_busy_nxt = 1'b0;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + AW'(1);
                end
            end

            S_RUN: begin
                // Core normally wins; once debug has lost STARVE_LIMIT cycles
                // in a row it takes the port for one beat.
                w_force_dbg   = bus.dbg_wvalid && (r_starve_cnt >= STARVE_MAX);
                w_core_wready = !w_force_dbg;
                w_dbg_wready  = w_force_dbg || !bus.core_wvalid;
                w_grant_core  = bus.core_wvalid && w_core_wready;
                w_grant_dbg   = bus.dbg_wvalid  && w_dbg_wready;

                if (w_grant_dbg || !bus.dbg_wvalid)
                    w_starve_cnt_nxt = '0;
                else if (r_starve_cnt != STARVE_MAX)
                    w_starve_cnt_nxt = r_starve_cnt + SCW'(1);

                // x0 is hardwired: the handshake completes but no write is issued.
                if (w_grant_core) begin
                    w_rf_we_nxt = (w_core_req.addr != '0);
                    w_rf_wr_nxt = w_core_req;
                end else if (w_grant_dbg) begin
                    w_rf_we_nxt = (w_dbg_req.addr != '0);
                    w_rf_wr_nxt = w_dbg_req;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_CLEAR;
            r_clr_ptr    <= AW'(1);
            r_starve_cnt <= '0;
            r_rf_we      <= 1'b0;
            r_rf_wr      <= '0;
            r_init_busy  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_ptr    <= w_clr_ptr_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
            r_rf_we      <= w_rf_we_nxt;
            r_rf_wr      <= w_rf_wr_nxt;
            r_init_busy  <= w_init_busy_nxt;
        end
    end

    assign bus.core_wready = w_core_wready;
    assign bus.dbg_wready  = w_dbg_wready;
    assign bus.rf_we       = r_rf_we;
    assign bus.rf_waddr    = r_rf_wr.addr;
    assign bus.rf_wdata    = r_rf_wr.data;
    assign bus.init_busy   = r_init_busy;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int SL   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_port_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();

    regfile_port_arbiter #(
        .NUM_REGS(NREG), .AW(AW), .DW(DW), .STARVE_LIMIT(SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    bit            m_run;
    int            m_starve;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_idle();
        bus_if.core_wvalid = 1'b0;
        bus_if.core_waddr  = '0;
        bus_if.core_wdata  = '0;
        bus_if.dbg_wvalid  = 1'b0;
        bus_if.dbg_waddr   = '0;
        bus_if.dbg_wdata   = '0;
    endtask

    // One RUN-mode cycle: drive, check readies, push expected rf output,
    // then pop and compare after the edge.
    task automatic drive_cycle(input logic cv, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                               input logic dv, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                               output bit gc, output bit gd);
        exp_t e;
        logic erc, erd;
        bit   frc;
        @(negedge clk);
        bus_if.core_wvalid = cv; bus_if.core_waddr = ca; bus_if.core_wdata = cd;
        bus_if.dbg_wvalid  = dv; bus_if.dbg_waddr  = da; bus_if.dbg_wdata  = dd;
        #1;
        if (m_run) begin
            frc = dv && (m_starve >= SL);
            erc = !frc;
            erd = frc || !cv;
        end else begin
            erc = 1'b0;
            erd = 1'b0;
        end
        total++;
        if (bus_if.core_wready !== erc) begin
            bad++;
            $display("FAIL core_wready: got %b want %b", bus_if.core_wready, erc);
        end
        total++;
        if (bus_if.dbg_wready !== erd) begin
            bad++;
            $display("FAIL dbg_wready: got %b want %b", bus_if.dbg_wready, erd);
        end
        gc = cv && erc;
        gd = dv && erd;
        if (gc) begin
            e = '{(ca != '0), ca, cd};
            m_addr = ca; m_data = cd;
        end else if (gd) begin
            e = '{(da != '0), da, dd};
            m_addr = da; m_data = dd;
        end else begin
            e = '{1'b0, m_addr, m_data};
        end
        sb.push_back(e);
        if (m_run) begin
            if (gd || !dv) m_starve = 0;
            else if (m_starve < SL) m_starve++;
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        total++;
        if ({bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, bus_if.init_busy} !==
            {e.we, e.addr, e.data, 1'b0}) begin
            bad++;
            $display("FAIL rf_out: got we=%b addr=%0d data=%h busy=%b want we=%b addr=%0d data=%h busy=0",
                     bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, bus_if.init_busy,
                     e.we, e.addr, e.data);
        end
    endtask

    task automatic idle_cycle();
        bit gc, gd;
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, gc, gd);
    endtask

    task automatic do_reset(input int n);
        logic [AW+DW+1:0] want;
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        m_run = 1'b0; m_starve = 0; m_addr = '0; m_data = '0;
        sb.delete();
        repeat (n) @(posedge clk);
        #1;
        want = {1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1};
        total++;
        if ({bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, bus_if.init_busy} !== want) begin
            bad++;
            $display("FAIL reset_state: got we=%b addr=%0d data=%h busy=%b want we=0 addr=0 data=0 busy=1",
                     bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, bus_if.init_busy);
        end
        total++;
        if ({bus_if.core_wready, bus_if.dbg_wready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: got %b%b want 00", bus_if.core_wready, bus_if.dbg_wready);
        end
    endtask

    // Releases reset and follows the clear walk; stop_at>0 returns after that edge.
    task automatic run_clear(input int stop_at);
        for (int k = 1; k <= NREG - 1; k++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            total++;
            if ({bus_if.core_wready, bus_if.dbg_wready} !== 2'b00) begin
                bad++;
                $display("FAIL clear_ready k=%0d: got %b%b want 00", k,
                         bus_if.core_wready, bus_if.dbg_wready);
            end
            @(posedge clk); #1;
            total++;
            if ({bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, bus_if.init_busy} !==
                {1'b1, AW'(k), {DW{1'b0}}, (k != NREG - 1)}) begin
                bad++;
                $display("FAIL clear_step k=%0d: got we=%b addr=%0d data=%h busy=%b want we=1 addr=%0d data=0 busy=%b",
                         k, bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, bus_if.init_busy,
                         k, (k != NREG - 1));
            end
            if (k == stop_at) return;
        end
        m_run = 1'b1; m_addr = AW'(NREG - 1); m_data = '0; m_starve = 0;
    endtask

    task automatic test_reset();
        do_reset(2);
    endtask

    task automatic test_clear();
        run_clear(0);
        idle_cycle();   // rf_we must drop: exactly 31 clear writes
    endtask

    task automatic test_core_write();
        bit gc, gd;
        drive_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, gc, gd);
        total++;
        if (gc !== 1'b1) begin bad++; $display("FAIL core_grant: got %b want 1", gc); end
        idle_cycle();
    endtask

    task automatic test_x0();
        bit gc, gd;
        drive_cycle(1'b1, 5'd0, 32'd7, 1'b0, '0, '0, gc, gd);
        total++;
        if (gc !== 1'b1) begin bad++; $display("FAIL x0_grant: got %b want 1", gc); end
        idle_cycle();
    endtask

    task automatic test_dbg_alone();
        bit gc, gd;
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd9, 32'h55, gc, gd);
        total++;
        if (gd !== 1'b1) begin bad++; $display("FAIL dbg_grant: got %b want 1", gd); end
        idle_cycle();
    endtask

    task automatic test_contention();
        bit gc, gd;
        int ci = 0;
        int di = 0;
        logic [9:0] pat = '0;
        for (int b = 0; b < 11; b++) begin
            // beat 11 presents no new debug request so nothing is withdrawn
            drive_cycle(1'b1, AW'(10 + ci), 32'hC000_0000 + ci,
                        (b < 10), AW'(20 + di), 32'hD000_0000 + di, gc, gd);
            if (b < 10) pat = {pat[8:0], gd};
            if (gc) ci++;
            if (gd) di++;
        end
        total++;
        if (pat !== 10'b0000100001) begin
            bad++;
            $display("FAIL grant_order: got %b want 0000100001 (1=debug)", pat);
        end
        idle_cycle();
    endtask

    task automatic test_same_addr();
        bit gc, gd;
        drive_cycle(1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd3, 32'hBBBB_0002, gc, gd);
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd3, 32'hBBBB_0002, gc, gd);
        total++;
        if (gd !== 1'b1) begin bad++; $display("FAIL same_addr_dbg_grant: got %b want 1", gd); end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        run_clear(10);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus_if.rf_we, bus_if.rf_waddr, bus_if.init_busy} !== {1'b0, {AW{1'b0}}, 1'b1}) begin
            bad++;
            $display("FAIL mid_reset: got we=%b addr=%0d busy=%b want we=0 addr=0 busy=1",
                     bus_if.rf_we, bus_if.rf_waddr, bus_if.init_busy);
        end
        run_clear(0);
        idle_cycle();
    endtask

    initial begin
        set_idle();
        m_run = 1'b0; m_starve = 0; m_addr = '0; m_data = '0;
        test_reset();
        test_clear();
        test_core_write();
        test_x0();
        test_dbg_alone();
        test_contention();
        test_same_addr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
